// File: rtl/seg7_capture_decoder.sv
// seg7_capture_decoder: samples a 7-segment pattern on a strobe edge, waits
// for it to settle, decodes it back to BCD, and keeps a two-digit history
// plus a saturating decode-error counter.
module seg7_capture_decoder #(
  parameter int SYNC_STAGES    = 2,
  parameter int STABLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  localparam int SW = $clog2(STABLE_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {IDLE, SETTLE, DECODE, REPORT} state_e;

  // synchroniser: {clear, strobe, seg[6:0]}
  logic [SYNC_STAGES-1:0][8:0] sync_q;
  logic [6:0] seg_s;
  logic       strb_s, clr_s;
  logic       strb_prev_q;

  state_e        state_q, state_d;
  logic [6:0]    cap_q, cap_d;
  logic [SW-1:0] stab_q, stab_d;
  logic [TW-1:0] to_q, to_d;
  logic [3:0]    new_q, new_d, prev_q, prev_d;
  logic [3:0]    err_cnt_q, err_cnt_d;
  logic          vld_q, vld_d, err_q, err_d, busy_q, busy_d;
  logic [3:0]    dec_digit;
  logic          dec_ok;
  logic          unused_uio;

  assign unused_uio = ^uio_in[6:0];

  assign seg_s  = sync_q[SYNC_STAGES-1][6:0];
  assign strb_s = sync_q[SYNC_STAGES-1][7];
  assign clr_s  = sync_q[SYNC_STAGES-1][8];

  // input flop chain; runs regardless of ena
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q      <= '0;
      strb_prev_q <= 1'b0;
    end else begin
      sync_q[0] <= {uio_in[7], ui_in};
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      strb_prev_q <= strb_s;
    end
  end

  // pattern lookup on the captured segments; anything unlisted is invalid
  always_comb begin
    dec_ok    = 1'b1;
    dec_digit = 4'd0;
    case (cap_q)
      7'h3F: dec_digit = 4'd0;
      7'h06: dec_digit = 4'd1;
      7'h5B: dec_digit = 4'd2;
      7'h4F: dec_digit = 4'd3;
      7'h66: dec_digit = 4'd4;
      7'h6D: dec_digit = 4'd5;
      7'h7D: dec_digit = 4'd6;
      7'h07: dec_digit = 4'd7;
      7'h7F: dec_digit = 4'd8;
      7'h6F: dec_digit = 4'd9;
      default: dec_ok = 1'b0;
    endcase
  end

  // next-state: pulses are set on the edge entering REPORT so they are
  // high exactly during the REPORT cycle
  always_comb begin
    state_d   = state_q;
    cap_d     = cap_q;
    stab_d    = stab_q;
    to_d      = to_q;
    new_d     = new_q;
    prev_d    = prev_q;
    err_cnt_d = err_cnt_q;
    vld_d     = 1'b0;
    err_d     = 1'b0;
    if (clr_s) begin
      state_d   = IDLE;
      new_d     = 4'd0;
      prev_d    = 4'd0;
      err_cnt_d = 4'd0;
    end else if (ena) begin
      case (state_q)
        IDLE: if (strb_s && !strb_prev_q) begin
          state_d = SETTLE;
          cap_d   = seg_s;
          stab_d  = SW'(1);
          to_d    = '0;
        end
        SETTLE: begin
          // cap is frozen once stable so DECODE sees the settled value
          if (stab_q == SW'(STABLE_CYCLES)) begin
            state_d = DECODE;
          end else if (to_q == TW'(TIMEOUT_CYCLES - 1)) begin
            state_d   = REPORT;
            err_d     = 1'b1;
            err_cnt_d = (err_cnt_q == 4'hF) ? 4'hF : err_cnt_q + 4'd1;
          end else begin
            if (seg_s == cap_q) begin
              stab_d = stab_q + SW'(1);
            end else begin
              cap_d  = seg_s;
              stab_d = SW'(1);
            end
            to_d = to_q + TW'(1);
          end
        end
        DECODE: begin
          state_d = REPORT;
          if (dec_ok) begin
            vld_d  = 1'b1;
            prev_d = new_q;
            new_d  = dec_digit;
          end else begin
            err_d     = 1'b1;
            err_cnt_d = (err_cnt_q == 4'hF) ? 4'hF : err_cnt_q + 4'd1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
    busy_d = (state_d != IDLE);
  end

  // state and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cap_q     <= '0;
      stab_q    <= '0;
      to_q      <= '0;
      new_q     <= '0;
      prev_q    <= '0;
      err_cnt_q <= '0;
      vld_q     <= 1'b0;
      err_q     <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cap_q     <= cap_d;
      stab_q    <= stab_d;
      to_q      <= to_d;
      new_q     <= new_d;
      prev_q    <= prev_d;
      err_cnt_q <= err_cnt_d;
      vld_q     <= vld_d;
      err_q     <= err_d;
      busy_q    <= busy_d;
    end
  end

  assign uo_out  = {prev_q, new_q};
  assign uio_out = {1'b0, busy_q, err_cnt_q, err_q, vld_q};
  assign uio_oe  = 8'h7F;

endmodule
